rotate_arbiter: RTL
===================

Name: rotate_arbiter

Overview:
Shares one 4-bit rotate-right datapath between two requesters (port A, port B), each issuing a 4-bit word plus 2-bit rotate amount. Round-robin arbitration, valid/ready handshakes on every channel, and a single registered output stage. Per-source completion counters are included for debug/visibility. Sits between two control FSMs and the downstream consumer of rotated words.

Parameters:
CNT_W, 8, width of each per-source completion counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  requester A has a request
a_ready  out  1  A request accepted this cycle (a_valid & a_ready)
a_data  in  4  A word to rotate
a_amt  in  2  A rotate-right amount 0..3
b_valid  in  1  requester B has a request
b_ready  out  1  B request accepted this cycle
b_data  in  4  B word
b_amt  in  2  B rotate-right amount
out_valid  out  1  out_data/out_src hold a result
out_ready  in  1  consumer takes result (out_valid & out_ready)
out_data  out  4  rotated word
out_src  out  1  0 = result for A, 1 = result for B
busy  out  1  out_valid & ~out_ready (stall indicator)
a_count  out  CNT_W  results for A delivered (output handshakes with out_src=0)
b_count  out  CNT_W  results for B delivered

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, a_count=0, b_count=0, rr pointer=A (A wins first tie). Ports reset-driven low during reset.
- Rotate function: amt 0 -> unchanged; 1 -> {d[0],d[3],d[2],d[1]}; 2 -> {d[1],d[0],d[3],d[2]}; 3 -> {d[2],d[1],d[0],d[3]}. Purely combinational inside the datapath.
- Output stage states: EMPTY (out_valid=0), FULL (out_valid=1).
- can_accept = EMPTY | (FULL & out_ready); same-cycle drain and refill is allowed (full throughput: one result/cycle).
- Grant (combinational, evaluated when can_accept): only A valid -> A; only B valid -> B; both -> source pointed to by rr. a_ready = can_accept & grant_A; b_ready = can_accept & grant_B; never both high.
- On accept: next cycle out_valid=1, out_data=rotated word, out_src=granted source. Latency exactly 1 cycle from accept to out_valid.
- rr updates only on an accept: rr <= other source than the one granted. No change on idle cycles.
- FULL & ~out_ready: out_data/out_src held stable; a_ready=b_ready=0; busy=1.
- FULL & out_ready & no requester valid -> EMPTY, out_valid=0; out_data retains last value.
- Counters increment on output handshake by out_src; wrap to 0 past 2^CNT_W-1. No saturation.
- Requester must hold valid/data/amt stable until ready; block does not register unaccepted requests.
- rst_n asserted mid-transfer: pending output dropped, counters cleared, rr back to A.

Decomposition:
- Shared package: CNT_W default, source encodings SRC_A=1'b0 / SRC_B=1'b1, state encodings EMPTY/FULL.
- One sub-module: rotr4 (combinational 4-bit rotate-right by amt, four 4:1 muxes); arbiter/output register/counters stay in the top.

Test Plan:
- Reset then A only: a_data=4'b1001, a_amt=1, out_ready=1 -> a_ready=1 same cycle; next cycle out_valid=1, out_data=4'b1100, out_src=0; a_count=1 after handshake.
- Both valid continuously, A={4'b0001,amt 2}, B={4'b1011,amt 3}, out_ready=1 -> grants alternate A,B,A,B; outputs 4'b0100(src0), 4'b0111(src1), repeating; one result per cycle.
- Back-pressure: result pending, out_ready=0 for 5 cycles with both valid -> a_ready=b_ready=0, busy=1, out_data stable; on out_ready=1 pending result taken and next request accepted same cycle.
- amt sweep on B only, b_data=4'b1000, amt 0..3 -> outputs 1000, 0100, 0010, 0001.
- Counter wrap (CNT_W=2): 5 A results -> a_count sequence 1,2,3,0,1; b_count stays 0.
- Async reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately, counts=0; after release with both valid, A granted first.

Source files
------------

// File: rtl/rotate_arbiter_pkg.sv
// Shared constants and types for the two-source rotate-right arbiter.
package rotate_arbiter_pkg;

  localparam int unsigned CntWDefault = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rotate_arbiter_rotr4.sv
// Combinational 4-bit rotate-right by 0..3 positions.
module rotate_arbiter_rotr4 (
  input  logic [3:0] data,
  input  logic [1:0] amt,
  output logic [3:0] result
);

  always_comb begin
    unique case (amt)
      2'd0: result = data;
      2'd1: result = {data[0], data[3:1]};
      2'd2: result = {data[1:0], data[3:2]};
      2'd3: result = {data[2:0], data[3]};
    endcase
  end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one rotate-right datapath between two requesters,
// with a single registered output stage and per-source delivery counters.
module rotate_arbiter
  import rotate_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [3:0]       a_data,
  input  logic [1:0]       a_amt,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [3:0]       b_data,
  input  logic [1:0]       b_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_src,
  output logic             busy,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  out_state_e       state_q, state_d;
  logic [3:0]       data_q, data_d;
  logic             src_q, src_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] a_cnt_q, b_cnt_q;

  logic       can_accept, grant_a, grant_b, accept, out_fire;
  logic [3:0] sel_data, rot_data;
  logic [1:0] sel_amt;

  assign out_valid  = (state_q == StFull);
  assign out_fire   = out_valid & out_ready;
  assign can_accept = ~out_valid | out_ready;

  // rr only breaks ties; a lone requester always wins.
  assign grant_a = a_valid & (~b_valid | (rr_q == SRC_A));
  assign grant_b = b_valid & (~a_valid | (rr_q == SRC_B));

  // Readies are forced low while reset is held.
  assign a_ready = rst_n & can_accept & grant_a;
  assign b_ready = rst_n & can_accept & grant_b;
  assign accept  = a_ready | b_ready;

  assign sel_data = grant_b ? b_data : a_data;
  assign sel_amt  = grant_b ? b_amt  : a_amt;

  rotate_arbiter_rotr4 u_rotr4 (
    .data   (sel_data),
    .amt    (sel_amt),
    .result (rot_data)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (accept) begin
      state_d = StFull;
      data_d  = rot_data;
      src_d   = grant_b ? SRC_B : SRC_A;
      rr_d    = grant_b ? SRC_A : SRC_B;
    end else if (out_fire) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= 4'b0000;
      src_q   <= SRC_A;
      rr_q    <= SRC_A;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      if (out_fire) begin
        if (src_q == SRC_B) begin
          b_cnt_q <= b_cnt_q + CNT_W'(1);
        end else begin
          a_cnt_q <= a_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign out_data = data_q;
  assign out_src  = src_q;
  assign busy     = out_valid & ~out_ready;
  assign a_count  = a_cnt_q;
  assign b_count  = b_cnt_q;

endmodule
